// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS memory stage. Turns the ALU result into a data-memory
// access (LB/LH/LW/LBU/LHU/SB/SH/SW) or passes it straight through. One write-back
// response is produced per accepted instruction.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready/stall  execute-stage handshake (stall = valid & ~ready)
//   req_opcode/addr/wdata/rd   instruction fields captured at acceptance
//   mem_req/we/addr/be/wdata   data-memory request, held until mem_ack
//   mem_ack/mem_rdata          data-memory completion and read data
//   rsp_valid/we/rd/data/exc   one-cycle write-back response
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_exc
);

  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(ACK_TIMEOUT);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;

  logic          r_mem_req,   w_mem_req_nxt;
  logic          r_mem_we,    w_mem_we_nxt;
  logic [29:0]   r_mem_addr,  w_mem_addr_nxt;
  logic [3:0]    r_mem_be,    w_mem_be_nxt;
  logic [31:0]   r_mem_wdata, w_mem_wdata_nxt;

  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic          r_rsp_we,    w_rsp_we_nxt;
  logic [4:0]    r_rsp_rd,    w_rsp_rd_nxt;
  logic [31:0]   r_rsp_data,  w_rsp_data_nxt;
  logic          r_rsp_exc,   w_rsp_exc_nxt;

  // Context of the in-flight memory instruction
  logic [TW-1:0] r_timer,     w_timer_nxt;
  logic [4:0]    r_rd,        w_rd_nxt;
  logic [1:0]    r_size,      w_size_nxt;
  logic          r_signed,    w_signed_nxt;
  logic [1:0]    r_off,       w_off_nxt;
  logic          r_is_load,   w_is_load_nxt;

  // Opcode decode of the presented instruction
  logic          w_is_load;
  logic          w_is_store;
  logic          w_mem_op;
  logic [1:0]    w_size;
  logic          w_signed;
  logic          w_misalign;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;

  // Lane extraction of the returned read data
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;

  // Classify opcode into load/store, access size and sign-extension
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size     = SZ_W;
    w_signed   = 1'b0;
    unique case (req_opcode)
      6'b100000: begin w_is_load  = 1'b1; w_size = SZ_B; w_signed = 1'b1; end
      6'b100001: begin w_is_load  = 1'b1; w_size = SZ_H; w_signed = 1'b1; end
      6'b100011: begin w_is_load  = 1'b1; w_size = SZ_W; end
      6'b100100: begin w_is_load  = 1'b1; w_size = SZ_B; end
      6'b100101: begin w_is_load  = 1'b1; w_size = SZ_H; end
      6'b101000: begin w_is_store = 1'b1; w_size = SZ_B; end
      6'b101001: begin w_is_store = 1'b1; w_size = SZ_H; end
      6'b101011: begin w_is_store = 1'b1; w_size = SZ_W; end
      default:   ;
    endcase
  end

  assign w_mem_op   = w_is_load | w_is_store;
  assign w_misalign = ((w_size == SZ_H) && req_addr[0]) ||
                      ((w_size == SZ_W) && (req_addr[1:0] != 2'b00));

  // Big-endian byte enables and lane-replicated store data
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    unique case (w_size)
      SZ_B: begin
        w_be    = 4'b1000 >> req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        w_be    = req_addr[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Select the addressed lane; offset 0 is the most significant byte
  always_comb begin
    w_byte = mem_rdata[31:24];
    unique case (r_off)
      2'd0: w_byte = mem_rdata[31:24];
      2'd1: w_byte = mem_rdata[23:16];
      2'd2: w_byte = mem_rdata[15:8];
      2'd3: w_byte = mem_rdata[7:0];
      default: ;
    endcase
    w_half = r_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    unique case (r_size)
      SZ_B:    w_load_data = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      SZ_H:    w_load_data = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_be_nxt    = r_mem_be;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_we_nxt    = r_rsp_we;
    w_rsp_rd_nxt    = r_rsp_rd;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_exc_nxt   = r_rsp_exc;
    w_timer_nxt     = r_timer;
    w_rd_nxt        = r_rd;
    w_size_nxt      = r_size;
    w_signed_nxt    = r_signed;
    w_off_nxt       = r_off;
    w_is_load_nxt   = r_is_load;

    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_rd_nxt      = req_rd;
          w_size_nxt    = w_size;
          w_signed_nxt  = w_signed;
          w_off_nxt     = req_addr[1:0];
          w_is_load_nxt = w_is_load;
          if (w_mem_op && !w_misalign) begin
            w_state_nxt     = S_ACCESS;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = w_is_store;
            w_mem_addr_nxt  = req_addr[31:2];
            w_mem_be_nxt    = w_be;
            w_mem_wdata_nxt = w_wdata;
            w_timer_nxt     = TW'(1);
          end else begin
            // Pass-through, or a misaligned access reported without touching memory
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rd_nxt    = req_rd;
            w_rsp_data_nxt  = req_addr;
            w_rsp_exc_nxt   = w_mem_op;
            w_rsp_we_nxt    = !w_mem_op && (req_rd != 5'd0);
          end
        end
      end

      S_ACCESS: begin
        // r_timer holds the index of the current ACCESS cycle; an ack on the last one wins
        if (mem_ack) begin
          w_state_nxt     = S_RESP;
          w_mem_req_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rd_nxt    = r_rd;
          w_rsp_exc_nxt   = 1'b0;
          w_rsp_we_nxt    = r_is_load && (r_rd != 5'd0);
          w_rsp_data_nxt  = r_is_load ? w_load_data : 32'd0;
        end else if (r_timer == TIMEOUT_CNT) begin
          w_state_nxt     = S_RESP;
          w_mem_req_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rd_nxt    = r_rd;
          w_rsp_exc_nxt   = 1'b1;
          w_rsp_we_nxt    = 1'b0;
          w_rsp_data_nxt  = 32'd0;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      S_RESP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 30'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rd    <= 5'd0;
      r_rsp_data  <= 32'd0;
      r_rsp_exc   <= 1'b0;
      r_timer     <= TW'(0);
      r_rd        <= 5'd0;
      r_size      <= 2'd0;
      r_signed    <= 1'b0;
      r_off       <= 2'd0;
      r_is_load   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_we    <= w_rsp_we_nxt;
      r_rsp_rd    <= w_rsp_rd_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_exc   <= w_rsp_exc_nxt;
      r_timer     <= w_timer_nxt;
      r_rd        <= w_rd_nxt;
      r_size      <= w_size_nxt;
      r_signed    <= w_signed_nxt;
      r_off       <= w_off_nxt;
      r_is_load   <= w_is_load_nxt;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign stall     = req_valid & (r_state != S_IDLE);

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

  assign rsp_valid = r_rsp_valid;
  assign rsp_we    = r_rsp_we;
  assign rsp_rd    = r_rsp_rd;
  assign rsp_data  = r_rsp_data;
  assign rsp_exc   = r_rsp_exc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard of expected write-back responses
// and a small variable-latency memory model.
module tb_mem_access_unit;

  localparam int unsigned ACK_TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = 6'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_we;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_exc;

  logic model_ack;
  logic tb_ack_extra = 1'b0;
  assign mem_ack = model_ack | tb_ack_extra;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int ack_lat = 0;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic        exc;
    logic [4:0]  rd;
    int          lat;
    bit          chk_data;
  } exp_t;
  exp_t sb[$];

  logic [5:0]  l_op   [5] = '{6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011};
  logic [31:0] l_addr [5] = '{32'h40, 32'h43, 32'h42, 32'h40, 32'h40};
  logic [31:0] l_data [5] = '{32'hFFFF_FF80, 32'h0000_0001, 32'h0000_7F01,
                              32'h0000_80FF, 32'h80FF_7F01};
  logic [3:0]  l_be   [5] = '{4'b1000, 4'b0001, 4'b0011, 4'b1100, 4'b1111};

  mem_access_unit #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
    .rsp_exc(rsp_exc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks the ack_lat-th cycle of a request (0 = never acks)
  initial begin : mem_model
    logic [31:0] mem [32];
    int cnt;
    int idx;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[16]   = 32'h80FF_7F01;
    model_ack = 1'b0;
    mem_rdata = 32'd0;
    cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      model_ack = 1'b0;
      if (rst_n && mem_req && ack_lat != 0) begin
        cnt++;
        if (cnt == ack_lat) begin
          idx       = int'(mem_addr[4:0]);
          model_ack = 1'b1;
          mem_rdata = mem[idx];
          if (mem_we)
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic we, input logic exc,
                      input logic [4:0] rd, input int lat, input bit chk_data);
    exp_t e;
    e.data = data; e.we = we; e.exc = exc; e.rd = rd; e.lat = lat; e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  // Wait for ready, present one instruction, return #1 after the acceptance edge
  task automatic present(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = addr;
    req_wdata  = wd;
    req_rd     = rd;
    @(posedge clk); #1;
    acc_cyc = cyc;
  endtask

  // Wait for the next response and compare it against the scoreboard head
  task automatic wait_rsp();
    int n = 0;
    exp_t e;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      if (rsp_valid) begin
        chk("rsp_lat", 32'(cyc - acc_cyc + 1), 32'(e.lat));
        chk("rsp_we", 32'(rsp_we), 32'(e.we));
        chk("rsp_exc", 32'(rsp_exc), 32'(e.exc));
        chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
        if (e.chk_data) chk("rsp_data", rsp_data, e.data);
      end
    end
    @(posedge clk); #1;
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Pass-through
    push(32'h0000_1234, 1'b1, 1'b0, 5'd5, 1, 1'b1);
    present(6'b000000, 32'h0000_1234, 32'd0, 5'd5);
    chk("pt_no_mem_req", 32'(mem_req), 32'd0);
    req_valid = 1'b0;
    wait_rsp();
    push(32'h0000_1234, 1'b0, 1'b0, 5'd0, 1, 1'b1);
    present(6'b000000, 32'h0000_1234, 32'd0, 5'd0);
    req_valid = 1'b0;
    wait_rsp();

    // Loads with ack in cycle 3; req_valid held to observe stall
    ack_lat = 3;
    for (int i = 0; i < 5; i++) begin
      push(l_data[i], 1'b1, 1'b0, 5'd8, 4, 1'b1);
      present(l_op[i], l_addr[i], 32'd0, 5'd8);
      chk("ld_mem_req", 32'(mem_req), 32'd1);
      chk("ld_mem_we", 32'(mem_we), 32'd0);
      chk("ld_mem_addr", 32'(mem_addr), 32'h10);
      chk("ld_mem_be", 32'(mem_be), 32'(l_be[i]));
      chk("ld_stall_c1", 32'(stall), 32'd1);
      @(posedge clk); #1;
      chk("ld_stall_c2", 32'(stall), 32'd1);
      req_valid = 1'b0;
      wait_rsp();
    end

    // Stores, then read back the merged word
    ack_lat = 1;
    push(32'd0, 1'b0, 1'b0, 5'd9, 2, 1'b1);
    present(6'b101000, 32'h41, 32'h0000_00AB, 5'd9);
    req_valid = 1'b0;
    chk("sb_mem_we", 32'(mem_we), 32'd1);
    chk("sb_mem_be", 32'(mem_be), 32'b0100);
    chk("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
    wait_rsp();
    push(32'd0, 1'b0, 1'b0, 5'd9, 2, 1'b1);
    present(6'b101001, 32'h42, 32'h0000_CDEF, 5'd9);
    req_valid = 1'b0;
    chk("sh_mem_we", 32'(mem_we), 32'd1);
    chk("sh_mem_be", 32'(mem_be), 32'b0011);
    chk("sh_mem_wdata", mem_wdata, 32'hCDEF_CDEF);
    wait_rsp();
    push(32'h80AB_CDEF, 1'b1, 1'b0, 5'd10, 2, 1'b1);
    present(6'b100011, 32'h40, 32'd0, 5'd10);
    req_valid = 1'b0;
    wait_rsp();

    // Misaligned accesses
    push(32'h42, 1'b0, 1'b1, 5'd4, 1, 1'b1);
    present(6'b100011, 32'h42, 32'd0, 5'd4);
    req_valid = 1'b0;
    chk("mis_lw_no_req", 32'(mem_req), 32'd0);
    wait_rsp();
    push(32'h41, 1'b0, 1'b1, 5'd4, 1, 1'b1);
    present(6'b101001, 32'h41, 32'h1234, 5'd4);
    req_valid = 1'b0;
    chk("mis_sh_no_req", 32'(mem_req), 32'd0);
    wait_rsp();

    // Timeout with no ack
    ack_lat = 0;
    push(32'd0, 1'b0, 1'b1, 5'd6, int'(ACK_TO) + 1, 1'b0);
    present(6'b100011, 32'h40, 32'd0, 5'd6);
    req_valid = 1'b0;
    for (int k = 1; k <= int'(ACK_TO); k++) begin
      chk("to_mem_req_held", 32'(mem_req), 32'd1);
      @(posedge clk); #1;
    end
    chk("to_mem_req_drop", 32'(mem_req), 32'd0);
    wait_rsp();

    // Ack on the last allowed cycle wins
    ack_lat = int'(ACK_TO);
    push(32'h80AB_CDEF, 1'b1, 1'b0, 5'd7, int'(ACK_TO) + 1, 1'b1);
    present(6'b100011, 32'h40, 32'd0, 5'd7);
    req_valid = 1'b0;
    wait_rsp();

    // Reset in cycle 2 of a pending LW
    ack_lat = 0;
    present(6'b100011, 32'h40, 32'd0, 5'd3);
    req_valid = 1'b0;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_mem_req", 32'(mem_req), 32'd0);
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_rsp_we", 32'(rsp_we), 32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tb_ack_extra = 1'b1;
    @(posedge clk); #1;
    tb_ack_extra = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("mrst_idle", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end

    // Pass-through after reset
    push(32'hDEAD_0000, 1'b1, 1'b0, 5'd31, 1, 1'b1);
    present(6'b001000, 32'hDEAD_0000, 32'd0, 5'd31);
    req_valid = 1'b0;
    wait_rsp();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
